// File: rtl/sdram_read_arbiter.sv
// SDRAM read-port arbiter: grants one of two requesters (background, sprite),
// issues a fixed-length burst read and steers returned beats back to the owner.
module sdram_read_arbiter #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned BURST_LEN = 8,   // 2..255
  parameter int unsigned TIMEOUT   = 255  // 1..255
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active low
  // Background pixel fetch path
  input  logic              bg_req,
  input  logic [ADDR_W-1:0] bg_addr,
  input  logic              bg_urgent,
  output logic              bg_gnt,
  output logic              bg_valid,
  output logic              bg_done,
  // Sprite fetch path
  input  logic              sp_req,
  input  logic [ADDR_W-1:0] sp_addr,
  output logic              sp_gnt,
  output logic              sp_valid,
  output logic              sp_done,
  // SDRAM controller read port
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [23:0]       rd_data,
  // Shared data and status
  output logic [23:0]       data_out,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {StIdle, StIssue, StBurst} state_e;

  localparam logic [7:0] BurstLenC = 8'(BURST_LEN);
  localparam logic [7:0] TimeoutC  = 8'(TIMEOUT);

  state_e            state_q, state_d;
  logic              owner_sp_q, owner_sp_d;  // 1: sprite owns the current burst
  logic              last_sp_q, last_sp_d;    // 1: sprite was served last
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [7:0]        tmo_cnt_q, tmo_cnt_d;
  logic [23:0]       data_q, data_d;
  logic              bg_gnt_q, bg_gnt_d;
  logic              sp_gnt_q, sp_gnt_d;
  logic              bg_valid_q, bg_valid_d;
  logic              sp_valid_q, sp_valid_d;
  logic              bg_done_q, bg_done_d;
  logic              sp_done_q, sp_done_d;
  logic              err_q, err_d;

  logic              bg_win;
  logic [7:0]        beat_inc;
  logic [7:0]        tmo_inc;

  // Urgent background always wins; a tie goes to whoever was not served last.
  assign bg_win = bg_req & (bg_urgent | ~sp_req | last_sp_q);

  // Saturating increments so counters never wrap.
  assign beat_inc = (beat_cnt_q == 8'hFF) ? beat_cnt_q : beat_cnt_q + 8'd1;
  assign tmo_inc  = (tmo_cnt_q == 8'hFF) ? tmo_cnt_q : tmo_cnt_q + 8'd1;

  // Next-state logic: arbitration, command handshake and beat steering.
  always_comb begin
    state_d    = state_q;
    owner_sp_d = owner_sp_q;
    last_sp_d  = last_sp_q;
    addr_d     = addr_q;
    beat_cnt_d = beat_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    data_d     = data_q;
    bg_gnt_d   = 1'b0;
    sp_gnt_d   = 1'b0;
    bg_valid_d = 1'b0;
    sp_valid_d = 1'b0;
    bg_done_d  = 1'b0;
    sp_done_d  = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bg_win) begin
          owner_sp_d = 1'b0;
          addr_d     = bg_addr;
          bg_gnt_d   = 1'b1;
          state_d    = StIssue;
        end else if (sp_req) begin
          owner_sp_d = 1'b1;
          addr_d     = sp_addr;
          sp_gnt_d   = 1'b1;
          state_d    = StIssue;
        end
      end

      StIssue: begin
        if (rd_ack) begin
          beat_cnt_d = 8'd0;
          tmo_cnt_d  = 8'd0;
          state_d    = StBurst;
        end
      end

      StBurst: begin
        if (rd_valid) begin
          data_d     = rd_data;
          bg_valid_d = ~owner_sp_q;
          sp_valid_d = owner_sp_q;
          beat_cnt_d = beat_inc;
          tmo_cnt_d  = 8'd0;
          if (beat_inc == BurstLenC) begin
            bg_done_d = ~owner_sp_q;
            sp_done_d = owner_sp_q;
            last_sp_d = owner_sp_q;
            state_d   = StIdle;
          end
        end else begin
          tmo_cnt_d = tmo_inc;
          // Abort; any beats still outstanding are dropped in IDLE.
          if (tmo_inc == TimeoutC) begin
            err_d     = 1'b1;
            bg_done_d = ~owner_sp_q;
            sp_done_d = owner_sp_q;
            last_sp_d = owner_sp_q;
            state_d   = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset favours background on the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      owner_sp_q <= 1'b0;
      last_sp_q  <= 1'b1;
      addr_q     <= '0;
      beat_cnt_q <= 8'd0;
      tmo_cnt_q  <= 8'd0;
      data_q     <= 24'd0;
      bg_gnt_q   <= 1'b0;
      sp_gnt_q   <= 1'b0;
      bg_valid_q <= 1'b0;
      sp_valid_q <= 1'b0;
      bg_done_q  <= 1'b0;
      sp_done_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_sp_q <= owner_sp_d;
      last_sp_q  <= last_sp_d;
      addr_q     <= addr_d;
      beat_cnt_q <= beat_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      data_q     <= data_d;
      bg_gnt_q   <= bg_gnt_d;
      sp_gnt_q   <= sp_gnt_d;
      bg_valid_q <= bg_valid_d;
      sp_valid_q <= sp_valid_d;
      bg_done_q  <= bg_done_d;
      sp_done_q  <= sp_done_d;
      err_q      <= err_d;
    end
  end

  assign bg_gnt   = bg_gnt_q;
  assign sp_gnt   = sp_gnt_q;
  assign bg_valid = bg_valid_q;
  assign sp_valid = sp_valid_q;
  assign bg_done  = bg_done_q;
  assign sp_done  = sp_done_q;
  assign err      = err_q;
  assign data_out = data_q;
  assign rd_addr  = addr_q;
  assign rd_req   = (state_q == StIssue);
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Directed bench for sdram_read_arbiter: burst flow, arbitration, timeout,
// asynchronous reset mid-burst and stray read data.
module tb_sdram_read_arbiter;

  localparam int unsigned AddrW    = 24;
  localparam int unsigned BurstLen = 8;
  localparam int unsigned Timeout  = 4;

  logic             clk;
  logic             rst;
  logic             bg_req, bg_urgent, sp_req;
  logic [AddrW-1:0] bg_addr, sp_addr;
  logic             bg_gnt, bg_valid, bg_done;
  logic             sp_gnt, sp_valid, sp_done;
  logic             rd_req, rd_ack, rd_valid;
  logic [AddrW-1:0] rd_addr;
  logic [23:0]      rd_data, data_out;
  logic             busy, err;

  int n_checks = 0;
  int n_pass   = 0;

  sdram_read_arbiter #(
    .ADDR_W   (AddrW),
    .BURST_LEN(BurstLen),
    .TIMEOUT  (Timeout)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .bg_req   (bg_req),
    .bg_addr  (bg_addr),
    .bg_urgent(bg_urgent),
    .bg_gnt   (bg_gnt),
    .bg_valid (bg_valid),
    .bg_done  (bg_done),
    .sp_req   (sp_req),
    .sp_addr  (sp_addr),
    .sp_gnt   (sp_gnt),
    .sp_valid (sp_valid),
    .sp_done  (sp_done),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_ack   (rd_ack),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .data_out (data_out),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Requests must already be driven; runs grant, ack and a full burst.
  task automatic do_burst(input string tag, input logic exp_bg, input logic [23:0] base);
    step();
    check_eq({tag, "_bg_gnt"}, {31'd0, bg_gnt}, {31'd0, exp_bg});
    check_eq({tag, "_sp_gnt"}, {31'd0, sp_gnt}, {31'd0, !exp_bg});
    bg_req    = 1'b0;
    sp_req    = 1'b0;
    bg_urgent = 1'b0;
    rd_ack    = 1'b1;
    step();
    rd_ack    = 1'b0;
    for (int i = 0; i < int'(BurstLen); i++) begin
      rd_valid = 1'b1;
      rd_data  = base + 24'(i);
      step();
      check_eq({tag, "_valid"}, {30'd0, bg_valid, sp_valid}, exp_bg ? 32'd2 : 32'd1);
      check_eq({tag, "_data"}, {8'd0, data_out}, {8'd0, base + 24'(i)});
    end
    check_eq({tag, "_done"}, {30'd0, bg_done, sp_done}, exp_bg ? 32'd2 : 32'd1);
    rd_valid = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b0; bg_req = 0; bg_urgent = 0; sp_req = 0;
    bg_addr = '0; sp_addr = '0; rd_ack = 0; rd_valid = 0; rd_data = '0;
    #12;
    // Reset state
    check_eq("rst_outs", {22'd0, bg_gnt, bg_valid, bg_done, sp_gnt, sp_valid, sp_done,
                          rd_req, busy, err, 1'b0}, 32'd0);
    check_eq("rst_data", {8'd0, data_out}, 32'd0);
    check_eq("rst_addr", {8'd0, rd_addr}, 32'd0);
    rst = 1'b1;
    step(); step();

    // Single background burst
    bg_req = 1'b1; bg_addr = 24'h000100;
    step();
    check_eq("s_bg_gnt", {31'd0, bg_gnt}, 32'd1);
    check_eq("s_rd_req", {31'd0, rd_req}, 32'd1);
    check_eq("s_busy", {31'd0, busy}, 32'd1);
    check_eq("s_rd_addr", {8'd0, rd_addr}, 32'h000100);
    check_eq("s_sp_gnt", {31'd0, sp_gnt}, 32'd0);
    bg_req = 1'b0; bg_addr = 24'hABCDEF;
    step();
    check_eq("s_gnt_pulse", {31'd0, bg_gnt}, 32'd0);
    check_eq("s_rd_req_hold", {31'd0, rd_req}, 32'd1);
    check_eq("s_addr_latched", {8'd0, rd_addr}, 32'h000100);
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    check_eq("s_rd_req_drop", {31'd0, rd_req}, 32'd0);
    check_eq("s_busy_burst", {31'd0, busy}, 32'd1);
    step();  // one idle beat slot inside BURST
    for (int i = 1; i <= 8; i++) begin
      rd_valid = 1'b1;
      rd_data  = 24'h111111 * 24'(i);
      step();
      check_eq("s_bg_valid", {31'd0, bg_valid}, 32'd1);
      check_eq("s_data", {8'd0, data_out}, 32'h111111 * i);
      check_eq("s_bg_done", {31'd0, bg_done}, (i == 8) ? 32'd1 : 32'd0);
      check_eq("s_sp_silent", {29'd0, sp_gnt, sp_valid, sp_done}, 32'd0);
    end
    rd_valid = 1'b0;
    check_eq("s_idle_after", {31'd0, busy}, 32'd0);
    step();
    check_eq("s_done_pulse", {30'd0, bg_valid, bg_done}, 32'd0);

    // Tie sequence from a fresh reset: background, sprite, background
    rst = 1'b0; #2; rst = 1'b1;
    step();
    bg_req = 1; sp_req = 1; do_burst("tie1", 1'b1, 24'h100000);
    bg_req = 1; sp_req = 1; do_burst("tie2", 1'b0, 24'h200000);
    bg_req = 1; sp_req = 1; do_burst("tie3", 1'b1, 24'h300000);

    // Urgent override: background just served, still wins with urgent
    bg_req = 1; sp_req = 1; bg_urgent = 1; do_burst("urg", 1'b1, 24'h400000);
    // Without urgent the tie goes to sprite
    bg_req = 1; sp_req = 1; do_burst("urg_rr", 1'b0, 24'h500000);

    // Timeout after 3 beats
    bg_req = 1; bg_addr = 24'h000200;
    step();
    check_eq("t_gnt", {31'd0, bg_gnt}, 32'd1);
    bg_req = 0; rd_ack = 1;
    step();
    rd_ack = 0;
    for (int i = 1; i <= 3; i++) begin
      rd_valid = 1'b1; rd_data = 24'h111111 * 24'(i);
      step();
    end
    rd_valid = 1'b0;
    check_eq("t_beat3", {8'd0, data_out}, 32'h333333);
    for (int i = 1; i <= 3; i++) begin
      step();
      check_eq("t_no_err_yet", {30'd0, err, bg_done}, 32'd0);
    end
    step();
    check_eq("t_err", {31'd0, err}, 32'd1);
    check_eq("t_bg_done", {31'd0, bg_done}, 32'd1);
    check_eq("t_idle", {31'd0, busy}, 32'd0);
    rd_valid = 1'b1; rd_data = 24'hDEAD00;
    step();
    rd_valid = 1'b0;
    check_eq("t_stray_valid", {30'd0, bg_valid, sp_valid}, 32'd0);
    check_eq("t_stray_data", {8'd0, data_out}, 32'h333333);
    check_eq("t_err_pulse", {31'd0, err}, 32'd0);

    // Reset mid-burst after beat 2
    bg_req = 1; bg_addr = 24'h000300;
    step();
    bg_req = 0; rd_ack = 1;
    step();
    rd_ack = 0;
    for (int i = 1; i <= 2; i++) begin
      rd_valid = 1'b1; rd_data = 24'h0A0A00 + 24'(i);
      step();
    end
    rd_valid = 1'b0;
    check_eq("r_pre_valid", {31'd0, bg_valid}, 32'd1);
    #2; rst = 1'b0; #1;
    check_eq("r_async_clear", {22'd0, bg_gnt, bg_valid, bg_done, sp_gnt, sp_valid, sp_done,
                               rd_req, busy, err, 1'b0}, 32'd0);
    check_eq("r_data_clear", {8'd0, data_out}, 32'd0);
    #2; rst = 1'b1;

    // Stray data in IDLE
    rd_valid = 1'b1; rd_data = 24'h777777;
    step();
    rd_valid = 1'b0;
    check_eq("x_idle_valid", {30'd0, bg_valid, sp_valid}, 32'd0);
    check_eq("x_idle_data", {8'd0, data_out}, 32'd0);
    check_eq("x_idle_busy", {31'd0, busy}, 32'd0);

    // New sprite request after reset, with stray data during ISSUE
    sp_req = 1; sp_addr = 24'h000400;
    step();
    sp_req = 0;
    check_eq("x_sp_gnt", {31'd0, sp_gnt}, 32'd1);
    check_eq("x_sp_addr", {8'd0, rd_addr}, 32'h000400);
    rd_valid = 1'b1; rd_data = 24'h999999;
    step();
    rd_valid = 1'b0;
    check_eq("x_issue_valid", {30'd0, bg_valid, sp_valid}, 32'd0);
    check_eq("x_issue_data", {8'd0, data_out}, 32'd0);
    check_eq("x_issue_rd_req", {31'd0, rd_req}, 32'd1);
    rd_ack = 1;
    step();
    rd_ack = 0;
    for (int i = 0; i < int'(BurstLen); i++) begin
      rd_valid = 1'b1; rd_data = 24'hC00000 + 24'(i);
      step();
      check_eq("x_sp_valid", {30'd0, bg_valid, sp_valid}, 32'd1);
    end
    rd_valid = 1'b0;
    check_eq("x_sp_done", {30'd0, bg_done, sp_done}, 32'd1);
    check_eq("x_sp_data", {8'd0, data_out}, 32'hC00007);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
